// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and settle-counter width.
package truth_table_sweeper_pkg;

    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Sweeper-to-host/DUT signal bundle; master is the sweeper side, slave is the host/DUT side.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    logic            start;
    logic [N_IN-1:0] vec;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_valid;

    modport master (
        input  start, dut_y,
        output vec, busy, done, pass, err_count, first_err_vec, first_err_valid
    );

    modport slave (
        output start, dut_y,
        input  vec, busy, done, pass, err_count, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/truth_table_sweeper_settle_counter.sv
// Loadable down-counter with a zero flag; paces how long each vector is held before sampling.
module tt_settle_counter
    import truth_table_sweeper_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                dec,
    input  logic [SETTLE_W-1:0] load_value,
    output logic                zero
);

    logic [SETTLE_W-1:0] count;

    // load wins over decrement so a new vector always starts with a full settle window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector in ascending order, compares the DUT output against a golden table,
// and reports mismatch count, first failing vector and pass/fail through a start/done handshake.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                        N_IN     = 4,
    parameter logic [(2**N_IN)-1:0]      EXPECTED = '0,
    parameter int                        SETTLE   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_sweeper_if.master  bus
);

    localparam logic [N_IN-1:0]     LAST_VEC  = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q;
    logic [N_IN:0]   err_q;
    logic [N_IN-1:0] first_vec_q;
    logic            first_valid_q;
    logic            busy_q, done_q, pass_q;

    logic cnt_load, cnt_dec, cnt_zero;
    logic accept, sample, mismatch, last_vec;

    tt_settle_counter u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (SETTLE_LD),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        accept   = 1'b0;
        sample   = 1'b0;
        last_vec = (vec_q == LAST_VEC);
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    sample = 1'b1;
                    if (last_vec) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // 4-state compare: an X or Z from the DUT is scored as a failure
    assign mismatch = sample && (bus.dut_y !== EXPECTED[vec_q]);

    // done and pass are registered together, so pass is already valid in the done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q         <= '0;
            err_q         <= '0;
            first_vec_q   <= '0;
            first_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                pass_q <= (err_q == '0);
            end
            if (accept) begin
                vec_q         <= '0;
                err_q         <= '0;
                first_vec_q   <= '0;
                first_valid_q <= 1'b0;
                busy_q        <= 1'b1;
            end
            if (sample) begin
                if (mismatch) begin
                    err_q <= err_q + 1'b1;
                    if (!first_valid_q) begin
                        first_vec_q   <= vec_q;
                        first_valid_q <= 1'b1;
                    end
                end
                if (last_vec) begin
                    busy_q <= 1'b0;
                end else begin
                    vec_q <= vec_q + 1'b1;
                end
            end
        end
    end

    assign bus.vec             = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_vec   = first_vec_q;
    assign bus.first_err_valid = first_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweeper instances (majority pass, majority with one flipped golden bit,
// 4-input table with controllable inversion) exercised with hand-computed expectations.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam logic [15:0] EXP_C = 16'hA5C3;

    truth_table_sweeper_if #(.N_IN(3)) if_a ();
    truth_table_sweeper_if #(.N_IN(3)) if_b ();
    truth_table_sweeper_if #(.N_IN(4)) if_c ();

    truth_table_sweeper #(.N_IN(3), .EXPECTED(8'b1110_1000), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    truth_table_sweeper #(.N_IN(3), .EXPECTED(8'b1100_1000), .SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );
    truth_table_sweeper #(.N_IN(4), .EXPECTED(16'hA5C3), .SETTLE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c)
    );

    logic [2:0] start_w = 3'b000;
    logic       invert_c = 1'b0;

    // 3-input majority gate as the device under sweep for A and B
    assign if_a.dut_y = (if_a.vec[2] & if_a.vec[1]) | (if_a.vec[2] & if_a.vec[0]) | (if_a.vec[1] & if_a.vec[0]);
    assign if_b.dut_y = (if_b.vec[2] & if_b.vec[1]) | (if_b.vec[2] & if_b.vec[0]) | (if_b.vec[1] & if_b.vec[0]);
    assign if_c.dut_y = EXP_C[if_c.vec] ^ invert_c;

    assign if_a.start = start_w[0];
    assign if_b.start = start_w[1];
    assign if_c.start = start_w[2];

    logic [2:0] done_w, busy_w, pass_w, valid_w;
    logic [7:0] err_w [3];
    logic [7:0] fev_w [3];
    logic [7:0] vec_w [3];

    assign done_w  = {if_c.done, if_b.done, if_a.done};
    assign busy_w  = {if_c.busy, if_b.busy, if_a.busy};
    assign pass_w  = {if_c.pass, if_b.pass, if_a.pass};
    assign valid_w = {if_c.first_err_valid, if_b.first_err_valid, if_a.first_err_valid};
    assign err_w[0] = {4'b0, if_a.err_count};
    assign err_w[1] = {4'b0, if_b.err_count};
    assign err_w[2] = {3'b0, if_c.err_count};
    assign fev_w[0] = {5'b0, if_a.first_err_vec};
    assign fev_w[1] = {5'b0, if_b.first_err_vec};
    assign fev_w[2] = {4'b0, if_c.first_err_vec};
    assign vec_w[0] = {5'b0, if_a.vec};
    assign vec_w[1] = {5'b0, if_b.vec};
    assign vec_w[2] = {4'b0, if_c.vec};

    int check_count = 0;
    int pass_count  = 0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Pulses start for one edge, checks the accept-edge clears, then waits (bounded) for done.
    // Returns at the falling edge of the done cycle; done_edge counts edges after the accept edge.
    task automatic applyStimulus(input int sel, output int done_edge, output int pass_acc);
        @(negedge clk);
        start_w[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_w[sel] = 1'b0;
        checkOutput($sformatf("s%0d accept busy", sel), busy_w[sel], 1);
        checkOutput($sformatf("s%0d accept err", sel), err_w[sel], 0);
        checkOutput($sformatf("s%0d accept valid", sel), valid_w[sel], 0);
        checkOutput($sformatf("s%0d accept vec", sel), vec_w[sel], 0);
        pass_acc  = pass_w[sel];
        done_edge = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_w[sel]) begin
                done_edge = k;
                break;
            end
        end
    endtask

    int de, pa;
    int first_done, second_done, low_cnt, done_cnt;

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy_w[0], 0);
        checkOutput("reset done", done_w[0], 0);
        checkOutput("reset pass", pass_w[0], 0);
        checkOutput("reset err", err_w[2], 0);
        checkOutput("reset vec", vec_w[2], 0);
        checkOutput("reset valid", valid_w[1], 0);
        rst_n = 1'b1;

        // majority gate against the correct table
        applyStimulus(0, de, pa);
        checkOutput("t1 done edge", de, 17);
        checkOutput("t1 pass", pass_w[0], 1);
        checkOutput("t1 err", err_w[0], 0);
        checkOutput("t1 valid", valid_w[0], 0);
        checkOutput("t1 vec holds last", vec_w[0], 7);
        checkOutput("t1 busy", busy_w[0], 0);

        // golden bit 5 flipped
        applyStimulus(1, de, pa);
        checkOutput("t2 done edge", de, 17);
        checkOutput("t2 pass", pass_w[1], 0);
        checkOutput("t2 err", err_w[1], 1);
        checkOutput("t2 first vec", fev_w[1], 5);
        checkOutput("t2 valid", valid_w[1], 1);

        // every row wrong
        invert_c = 1'b1;
        applyStimulus(2, de, pa);
        checkOutput("t3 done edge", de, 17);
        checkOutput("t3 err", err_w[2], 16);
        checkOutput("t3 first vec", fev_w[2], 0);
        checkOutput("t3 valid", valid_w[2], 1);
        checkOutput("t3 pass", pass_w[2], 0);
        @(negedge clk);
        checkOutput("t3 done one cycle", done_w[2], 0);

        // failing sweep followed by a passing one
        invert_c = 1'b0;
        applyStimulus(2, de, pa);
        checkOutput("t6 pass kept at accept", pa, 0);
        checkOutput("t6 done edge", de, 17);
        checkOutput("t6 pass", pass_w[2], 1);
        checkOutput("t6 err", err_w[2], 0);
        checkOutput("t6 valid", valid_w[2], 0);

        // asynchronous reset in the middle of a failing sweep
        invert_c = 1'b1;
        @(negedge clk);
        start_w[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_w[2] = 1'b0;
        for (int k = 0; k < 20 && vec_w[2] != 8'd3; k++) @(negedge clk);
        checkOutput("t4 reached vec3", vec_w[2], 3);
        checkOutput("t4 err before reset", err_w[2], 3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4 busy after reset", busy_w[2], 0);
        checkOutput("t4 vec after reset", vec_w[2], 0);
        checkOutput("t4 err after reset", err_w[2], 0);
        checkOutput("t4 valid after reset", valid_w[2], 0);
        @(negedge clk);
        rst_n = 1'b1;
        invert_c = 1'b0;
        applyStimulus(2, de, pa);
        checkOutput("t4 restart done edge", de, 17);
        checkOutput("t4 restart pass", pass_w[2], 1);
        checkOutput("t4 restart err", err_w[2], 0);
        checkOutput("t4 restart vec", vec_w[2], 15);

        // start held high: back-to-back sweeps
        @(negedge clk);
        start_w[0] = 1'b1;
        @(posedge clk);
        first_done = -1;
        second_done = -1;
        low_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_w[0]) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
                if (k <= 33) done_cnt++;
            end
            if (!busy_w[0] && k <= 33) low_cnt++;
        end
        start_w[0] = 1'b0;
        checkOutput("t5 first done edge", first_done, 17);
        checkOutput("t5 second done edge", second_done, 35);
        checkOutput("t5 busy low cycles", low_cnt, 2);
        checkOutput("t5 done pulses", done_cnt, 1);
        repeat (25) @(negedge clk);
        checkOutput("t5 final busy", busy_w[0], 0);
        checkOutput("t5 final pass", pass_w[0], 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
